// File: rtl/logic_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : logic_sweep_pkg
//  Purpose  : Shared types and helpers for the logic-function sweeper.
//             Holds the FSM state enum, the two single-bit logic functions
//             and a popcount helper.
//  Revision : 1.0  initial release
// ============================================================================
package logic_sweep_pkg;

    // Widest operand the sweeper supports. The popcount helper is sized for it.
    localparam int MAX_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    // x = ~c ^ (a|b), evaluated on one bit position
    function automatic logic f_x(input logic a, input logic b, input logic c);
        return ~c ^ (a | b);
    endfunction

    // y = (a|b) & (~(a&b) ^ (a|b)), evaluated on one bit position.
    // Kept in its original form even though it reduces to a&b.
    function automatic logic f_y(input logic a, input logic b);
        return (a | b) & (~(a & b) ^ (a | b));
    endfunction

    // Number of set bits in an operand of up to MAX_N bits
    function automatic logic [3:0] popcount(input logic [MAX_N-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_N; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_func_core.sv
`default_nettype none
// ============================================================================
//  Module   : logic_func_core
//  Purpose  : Purely combinational N-bit evaluation of the x/y functions.
//  Ports    : a_i, b_i, c_i  N-bit operands
//             x_o            ~c ^ (a|b)
//             y_o            (a|b) & (~(a&b) ^ (a|b))
//  Revision : 1.0  initial release
// ============================================================================
module logic_func_core
    import logic_sweep_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] c_i,
    output logic [N-1:0] x_o,
    output logic [N-1:0] y_o
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign x_o[i] = f_x(a_i[i], b_i[i], c_i[i]);
        assign y_o[i] = f_y(a_i[i], b_i[i]);
    end

endmodule
`default_nettype wire

// File: rtl/logic_func_sweeper.sv
`default_nettype none
// ============================================================================
//  Module   : logic_func_sweeper
//  Purpose  : Clocked evaluator of x = ~c ^ (a|b) and
//             y = (a|b) & (~(a&b) ^ (a|b)) over N-bit operands.
//             Direct mode: one operand set per valid/ready handshake,
//             result one cycle later.
//             Sweep mode : steps {a,b,c} through all 2^(3N) combinations,
//             accumulating the popcounts of x and y.
//  Ports    : clk, rst_n          clock, asynchronous active-low reset
//             start, abort        sweep request / sweep termination
//             in_valid, in_ready  direct-mode handshake
//             a_in, b_in, c_in    direct operands
//             x_out, y_out        registered results, out_valid qualifies
//             busy, done          sweep in progress / completion pulse
//             x_ones, y_ones      accumulated popcounts of the sweep
//             sig                 sweep signature (only with the macro)
//  Options  : LOGIC_SWEEP_SIGNATURE_EN adds the sig output, a rotate-xor
//             signature of every {x,y} produced during a sweep.
//  Revision : 1.0  initial release
// ============================================================================
module logic_func_sweeper
    import logic_sweep_pkg::*;
#(
    parameter  int N     = 1,
    localparam int CNT_W = 3*N + $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a_in,
    input  logic [N-1:0]     b_in,
    input  logic [N-1:0]     c_in,
    output logic [N-1:0]     x_out,
    output logic [N-1:0]     y_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] x_ones,
    output logic [CNT_W-1:0] y_ones
`ifdef LOGIC_SWEEP_SIGNATURE_EN
    ,
    output logic [2*N-1:0]   sig
`endif
);

    localparam int CNT_BITS = 3*N;

    state_e               state_q;
    logic [CNT_BITS-1:0]  cnt_q;
    logic [CNT_BITS-1:0]  cnt_d;
    logic [N-1:0]         x_out_q;
    logic [N-1:0]         y_out_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic [CNT_W-1:0]     x_ones_q;
    logic [CNT_W-1:0]     y_ones_q;
    logic [CNT_W-1:0]     x_ones_d;
    logic [CNT_W-1:0]     y_ones_d;

    logic [N-1:0]         op_a;
    logic [N-1:0]         op_b;
    logic [N-1:0]         op_c;
    logic [N-1:0]         fx;
    logic [N-1:0]         fy;
    logic [MAX_N-1:0]     fx_ext;
    logic [MAX_N-1:0]     fy_ext;
    logic                 last_vec;

    // The single function core is shared: during a sweep the counter
    // drives it, otherwise the direct operands do.
    always_comb begin
        if (state_q == SWEEP) begin
            op_a = cnt_q[CNT_BITS-1 -: N];
            op_b = cnt_q[2*N-1 -: N];
            op_c = cnt_q[N-1:0];
        end else begin
            op_a = a_in;
            op_b = b_in;
            op_c = c_in;
        end
    end

    logic_func_core #(
        .N (N)
    ) u_core (
        .a_i (op_a),
        .b_i (op_b),
        .c_i (op_c),
        .x_o (fx),
        .y_o (fy)
    );

    // Widen the results to the popcount helper's fixed width
    always_comb begin
        fx_ext        = '0;
        fy_ext        = '0;
        fx_ext[N-1:0] = fx;
        fy_ext[N-1:0] = fy;
    end

    assign x_ones_d = x_ones_q + CNT_W'(popcount(fx_ext));
    assign y_ones_d = y_ones_q + CNT_W'(popcount(fy_ext));
    assign cnt_d    = cnt_q + CNT_BITS'(1);
    assign last_vec = (cnt_q == '1);

    // start has priority over a direct transfer in IDLE
    assign in_ready = (state_q == IDLE) && !start;

`ifdef LOGIC_SWEEP_SIGNATURE_EN
    logic [2*N-1:0] sig_q;
    logic [2*N-1:0] sig_d;

    generate
        if (N == 1) begin : g_sig_rot1
            assign sig_d = {sig_q[0], sig_q[1]} ^ {fx, fy};
        end else begin : g_sig_rotn
            assign sig_d = {sig_q[2*N-2:0], sig_q[2*N-1]} ^ {fx, fy};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (state_q == IDLE && start) begin
            sig_q <= '0;
        end else if (state_q == SWEEP && !abort) begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            x_ones_q    <= '0;
            y_ones_q    <= '0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= SWEEP;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        x_ones_q <= '0;
                        y_ones_q <= '0;
                    end else if (in_valid) begin
                        x_out_q     <= fx;
                        y_out_q     <= fy;
                        out_valid_q <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        // Vector under evaluation is dropped, counters keep
                        // their partial sums.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        x_out_q     <= fx;
                        y_out_q     <= fy;
                        out_valid_q <= 1'b1;
                        x_ones_q    <= x_ones_d;
                        y_ones_q    <= y_ones_d;
                        cnt_q       <= cnt_d;
                        if (last_vec) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign x_ones    = x_ones_q;
    assign y_ones    = y_ones_q;

endmodule
`default_nettype wire

// File: doc/logic_func_sweeper.md
Name: logic_func_sweeper

Overview:
- Parametrised, clocked successor to the lab's 3-input logic-function block.
- Computes x = ~c ^ (a|b) and y = (a|b) & (~(a&b) ^ (a|b)) bitwise over N-bit operands a, b and c.
- Two modes:
  - Direct: evaluates one operand set through a valid/ready handshake.
  - Sweep: exhaustively steps through all 2^(3N) operand combinations and counts the 1-bits produced on x and y.
- Used as the self-checking exhaustive evaluator in the DSD experiment set.

Parameters:
- N, 1, operand width in bits; legal range 1..8.
- CNT_W, 3*N+$clog2(N)+1, width of the ones counters; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an exhaustive sweep; sampled only in IDLE.
- abort  input  1  terminate a sweep in progress.
- in_valid  input  1  direct-mode operand valid.
- in_ready  output  1  direct-mode operand accept; equals (state==IDLE && !start).
- a_in  input  N  direct operand a.
- b_in  input  N  direct operand b.
- c_in  input  N  direct operand c.
- x_out  output  N  registered x result.
- y_out  output  N  registered y result.
- out_valid  output  1  x_out/y_out hold a new result this cycle.
- busy  output  1  high in SWEEP.
- done  output  1  one-cycle pulse when a sweep completes.
- x_ones  output  CNT_W  accumulated popcount of x over the sweep.
- y_ones  output  CNT_W  accumulated popcount of y over the sweep.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset: state=IDLE. All of the following are 0 immediately on rst_n low: x_out, y_out, out_valid, busy, done, x_ones, y_ones, sweep counter.
- States: IDLE, SWEEP, DONE.
- IDLE, start=1:
  - Next state SWEEP; cnt<=0; x_ones<=0; y_ones<=0.
  - in_valid is ignored that cycle; in_ready is 0.
- IDLE, in_valid=1, start=0:
  - The handshake completes.
  - Next cycle: x_out/y_out = f(a_in,b_in,c_in) and out_valid=1. Latency 1.
  - Back-to-back transfers are allowed every cycle.
  - The counters are not touched.
- SWEEP:
  - Each cycle, cnt is split MSB-first as {a,b,c}, each N bits.
  - Next cycle: x_out/y_out hold the result and out_valid=1.
  - x_ones += popcount(x) and y_ones += popcount(y) in the same cycle as x_out/y_out update.
  - cnt increments by 1.
  - When cnt == 2^(3N)-1, next state is DONE.
- DONE:
  - done=1, out_valid=1 for the final vector, and the counters hold their final values.
  - Next state IDLE.
- Counters hold their values in IDLE until the next start.
- Sweep timing: start to done is 2^(3N)+1 cycles. out_valid is continuous for 2^(3N) cycles.
- Counter width: no overflow is possible, since the maximum count is N*2^(3N) < 2^CNT_W.
- abort in SWEEP:
  - Next state IDLE; the vector under evaluation is discarded (no out_valid).
  - No done pulse; the counters hold their partial values.
  - If abort and the terminal count coincide, abort wins.
- abort in IDLE or DONE: no effect.
- Reset asserted mid-sweep: immediate return to the reset state; no done.
- Functions are pure bitwise. For N=1, y reduces to a&b; the RTL implements the stated expression.

Optional Feature:
- Macro: LOGIC_SWEEP_SIGNATURE_EN.
- With the macro defined:
  - Output port sig [2N-1:0] is added, cleared at sweep start.
  - On each sweep vector: sig <= rotl(sig,1) ^ {x,y}.
  - sig is final when done=1.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package logic_sweep_pkg:
  - state_e enum {IDLE, SWEEP, DONE}.
  - Functions f_x(a,b,c) and f_y(a,b) defined bitwise.
  - popcount function.
- Sub-module logic_func_core: purely combinational, N-bit x/y evaluation. Instantiated once and shared by the direct and sweep paths through an operand mux.

Test Plan:
- N=1, in_valid with a=1,b=1,c=0 -> next cycle x_out=0, y_out=1, out_valid=1. Then a=0,b=0,c=0 -> x_out=1, y_out=0.
- N=1, start pulse -> out_valid for 8 cycles, done 9 cycles after start; x_ones=4, y_ones=2. With LOGIC_SWEEP_SIGNATURE_EN, sig=2'b00.
- N=2, start -> done after 65 cycles; x_ones=64, y_ones=32; busy high for 64 cycles.
- N=2, start then abort on the 10th SWEEP cycle -> no done; IDLE next cycle; counters frozen at the partial sums of vectors 0..8.
- start and in_valid in the same IDLE cycle -> in_ready=0, sweep starts, direct operand dropped. rst_n low mid-sweep -> all outputs 0 immediately, busy=0.
- Direct back-to-back: in_valid held 4 cycles with changing operands -> 4 consecutive out_valid cycles, each with the matching result one cycle later.
